// File: rtl/gnn_load_multi_if.sv
// Load-engine bus: instruction/control, DRAM read request, AXI4-Stream beats and buffer-bank writes.
// The master modport is the load engine's view; slave is the surrounding system's view.
interface gnn_load_multi_if #(
  parameter int LOAD_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int NUM_BUF            = 3,
  parameter int BUF_ADDR_WIDTH     = 11
);
  logic                                ap_start;
  logic                                ap_done;
  logic                                load_error;
  logic                                busy;
  logic [C_M_AXI_ADDR_WIDTH-1:0]       ctrl_addr_offset;
  logic [LOAD_INST_LENGTH-1:0]         ctrl_instruction;
  logic [C_M_AXI_ADDR_WIDTH-1:0]       dram_xfer_start_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]        dram_xfer_size_in_bytes;
  logic                                read_start;
  logic                                read_done;
  logic                                data_tvalid;
  logic                                data_tready;
  logic                                data_tlast;
  logic [C_M_AXI_DATA_WIDTH-1:0]       data_tdata;
  logic [NUM_BUF-1:0]                  buf_wr_valid;
  logic [NUM_BUF*BUF_ADDR_WIDTH-1:0]   buf_wr_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]       buf_wr_data;

  modport master (
    input  ap_start, ctrl_addr_offset, ctrl_instruction, read_done,
           data_tvalid, data_tlast, data_tdata,
    output ap_done, load_error, busy, dram_xfer_start_addr, dram_xfer_size_in_bytes,
           read_start, data_tready, buf_wr_valid, buf_wr_addr, buf_wr_data
  );

  modport slave (
    output ap_start, ctrl_addr_offset, ctrl_instruction, read_done,
           data_tvalid, data_tlast, data_tdata,
    input  ap_done, load_error, busy, dram_xfer_start_addr, dram_xfer_size_in_bytes,
           read_start, data_tready, buf_wr_valid, buf_wr_addr, buf_wr_data
  );
endinterface

// File: rtl/gnn_load_multi.sv
// Multi-buffer load engine: decodes one load instruction, requests a DRAM read and writes the
// returned stream into the selected buffer(s). Define LOAD_MULTI_BROADCAST_EN to allow multi-hot groups.
module gnn_load_multi #(
  parameter int LOAD_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int NUM_BUF            = 3,
  parameter int BUF_ADDR_WIDTH     = 11
) (
  input logic              kernel_clk,
  input logic              kernel_rst,
  gnn_load_multi_if.master ld
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  function automatic logic is_onehot(input logic [NUM_BUF-1:0] g);
    return (g != '0) && ((g & (g - NUM_BUF'(1))) == '0);
  endfunction

  // Buffer address wraps modulo 2^BUF_ADDR_WIDTH.
  function automatic logic [BUF_ADDR_WIDTH-1:0] wrap_addr(input logic [15:0] base,
                                                          input logic [15:0] off);
    logic [31:0] sum;
    sum = {16'd0, base} + {16'd0, off};
    return sum[BUF_ADDR_WIDTH-1:0];
  endfunction

  logic [2:0]                    state;
  logic [NUM_BUF-1:0]            group_r;
  logic [15:0]                   buf_start_r;
  logic [15:0]                   beat_len_r;
  logic [15:0]                   dram_start_r;
  logic [15:0]                   byte_len_r;
  logic [15:0]                   count_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0] offset_r;
  logic                          rd_done_seen;
  logic                          load_error_r;
  logic [NUM_BUF-1:0]            wr_vld_p1;
  logic [BUF_ADDR_WIDTH-1:0]     wr_addr_p1;
  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data_p1;

  logic group_ok;
  logic tready;
  logic beat;
  logic rd_any;
  logic short_last;
  logic unused_inst_bits;

`ifdef LOAD_MULTI_BROADCAST_EN
  assign group_ok = |group_r;
`else
  assign group_ok = is_onehot(group_r);
`endif

  assign unused_inst_bits = ^ld.ctrl_instruction[31:NUM_BUF];
  assign tready     = (state == S_STREAM) || (state == S_DRAIN);
  assign beat       = ld.data_tvalid && tready;
  assign rd_any     = rd_done_seen || ld.read_done;
  assign short_last = ld.data_tlast && ((count_r + 16'd1) != beat_len_r);

  assign ld.busy                    = (state != S_IDLE);
  assign ld.read_start              = (state == S_ISSUE);
  assign ld.ap_done                 = (state == S_DONE);
  assign ld.data_tready             = tready;
  assign ld.load_error              = load_error_r;
  assign ld.dram_xfer_start_addr    = offset_r + {{(C_M_AXI_ADDR_WIDTH-16){1'b0}}, dram_start_r};
  assign ld.dram_xfer_size_in_bytes = {{(C_XFER_SIZE_WIDTH-16){1'b0}}, byte_len_r};
  assign ld.buf_wr_valid            = wr_vld_p1;
  assign ld.buf_wr_addr             = {NUM_BUF{wr_addr_p1}};
  assign ld.buf_wr_data             = wr_data_p1;

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state        <= S_IDLE;
      group_r      <= '0;
      buf_start_r  <= '0;
      beat_len_r   <= '0;
      dram_start_r <= '0;
      byte_len_r   <= '0;
      count_r      <= '0;
      offset_r     <= '0;
      rd_done_seen <= 1'b0;
      load_error_r <= 1'b0;
      wr_vld_p1    <= '0;
      wr_addr_p1   <= '0;
      wr_data_p1   <= '0;
    end else begin
      wr_vld_p1 <= '0;
      if (ld.read_done && (state != S_IDLE))
        rd_done_seen <= 1'b1;
      case (state)
        S_IDLE: begin
          if (ld.ap_start) begin
            group_r      <= ld.ctrl_instruction[NUM_BUF-1:0];
            buf_start_r  <= ld.ctrl_instruction[47:32];
            beat_len_r   <= ld.ctrl_instruction[63:48];
            dram_start_r <= ld.ctrl_instruction[79:64];
            byte_len_r   <= ld.ctrl_instruction[95:80];
            offset_r     <= ld.ctrl_addr_offset;
            count_r      <= '0;
            rd_done_seen <= 1'b0;
            load_error_r <= 1'b0;
            state        <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!group_ok) begin
            load_error_r <= 1'b1;
            state        <= S_DONE;
          end else if (beat_len_r == 16'd0) begin
            state <= S_DONE;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_STREAM;
        // p0 -> p1: an accepted beat becomes a buffer write on the following cycle.
        S_STREAM: begin
          if (count_r == beat_len_r) begin
            state <= rd_any ? S_DONE : S_DRAIN;
          end else if (beat) begin
            wr_vld_p1  <= group_r;
            wr_addr_p1 <= wrap_addr(buf_start_r, count_r);
            wr_data_p1 <= ld.data_tdata;
            count_r    <= count_r + 16'd1;
            if (short_last) begin
              load_error_r <= 1'b1;
              state        <= rd_any ? S_DONE : S_DRAIN;
            end
          end
        end
        S_DRAIN: if (rd_any) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gnn_load_multi.sv
// Directed bench for gnn_load_multi: hand-computed vectors covering normal loads, gaps, wrap,
// zero length, group errors, short stream and mid-stream reset.
module tb_gnn_load_multi;
  localparam int LIL = 96;
  localparam int AW  = 64;
  localparam int DW  = 512;
  localparam int XW  = 32;
  localparam int NB  = 3;
  localparam int BAW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gnn_load_multi_if #(.LOAD_INST_LENGTH(LIL), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
                      .C_XFER_SIZE_WIDTH(XW), .NUM_BUF(NB), .BUF_ADDR_WIDTH(BAW)) ld_if ();

  gnn_load_multi #(.LOAD_INST_LENGTH(LIL), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
                   .C_XFER_SIZE_WIDTH(XW), .NUM_BUF(NB), .BUF_ADDR_WIDTH(BAW)) dut (
    .kernel_clk (clk),
    .kernel_rst (rst),
    .ld         (ld_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_rs, n_done, rs_cyc, done_cyc, start_cyc, last_beat_cyc, rd_cyc;
  logic [NB-1:0]     wr_vld_q[$];
  logic [NB*BAW-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ld_if.buf_wr_valid != '0) begin
      wr_vld_q.push_back(ld_if.buf_wr_valid);
      wr_addr_q.push_back(ld_if.buf_wr_addr);
      wr_data_q.push_back(ld_if.buf_wr_data[31:0]);
    end
    if (ld_if.read_start) begin n_rs++; rs_cyc = cyc; end
    if (ld_if.ap_done) begin n_done++; done_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LIL-1:0] build_inst(input logic [NB-1:0] grp, input logic [15:0] bstart,
                                                input logic [15:0] blen, input logic [15:0] dstart,
                                                input logic [15:0] bytes);
    logic [LIL-1:0] inst;
    inst = '0;
    inst[NB-1:0]  = grp;
    inst[47:32]   = bstart;
    inst[63:48]   = blen;
    inst[79:64]   = dstart;
    inst[95:80]   = bytes;
    return inst;
  endfunction

  // Runs one instruction; nbeats beats are offered, beat tlast_idx carries tlast (-1 for none).
  task automatic run_load(input logic [NB-1:0] grp, input logic [15:0] bstart, input logic [15:0] blen,
                          input int nbeats, input int tlast_idx, input bit gaps, input bit rd_early);
    int i, it;
    wr_vld_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    n_rs = 0; n_done = 0; rs_cyc = -1; done_cyc = -1; last_beat_cyc = -1; rd_cyc = -1;
    @(negedge clk);
    ld_if.ctrl_instruction = build_inst(grp, bstart, blen, 16'h0040, 16'h0100);
    ld_if.ctrl_addr_offset = 64'h1000_0000;
    ld_if.ap_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    ld_if.ap_start = 1'b0;
    i = 0; it = 0;
    while (i < nbeats && it < 200) begin
      @(negedge clk);
      ld_if.read_done   = rd_early && (it == 0);
      if (rd_early && it == 0) rd_cyc = cyc;
      ld_if.data_tvalid = gaps ? (it % 2 == 0) : 1'b1;
      ld_if.data_tdata  = DW'(100 + i);
      ld_if.data_tlast  = (i == tlast_idx);
      it++;
      if (ld_if.data_tvalid && ld_if.data_tready) begin
        last_beat_cyc = cyc;
        i++;
      end
    end
    @(negedge clk);
    ld_if.data_tvalid = 1'b0;
    ld_if.data_tlast  = 1'b0;
    ld_if.read_done   = 1'b0;
    if (i < nbeats) chk("beat_timeout", 64'(i), 64'(nbeats));
    if (!rd_early && nbeats > 0) begin
      @(negedge clk);
      ld_if.read_done = 1'b1;
      rd_cyc = cyc;
      @(negedge clk);
      ld_if.read_done = 1'b0;
    end
    for (int k = 0; k < 30 && n_done == 0; k++) @(negedge clk);
    if (n_done == 0) chk("done_timeout", 64'(n_done), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input logic [NB-1:0] grp, input int bstart, input int n);
    chk({tag, "_nwr"}, 64'(wr_vld_q.size()), 64'(n));
    for (int k = 0; k < n && k < wr_vld_q.size(); k++) begin
      chk($sformatf("%s_vld%0d", tag, k), 64'(wr_vld_q[k]), 64'(grp));
      chk($sformatf("%s_data%0d", tag, k), 64'(wr_data_q[k]), 64'(100 + k));
      for (int b = 0; b < NB; b++)
        if (grp[b])
          chk($sformatf("%s_addr%0d_b%0d", tag, k, b), 64'(wr_addr_q[k][b*BAW +: BAW]),
              64'((bstart + k) % (1 << BAW)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    ld_if.ap_start = 1'b0; ld_if.ctrl_addr_offset = '0; ld_if.ctrl_instruction = '0;
    ld_if.read_done = 1'b0; ld_if.data_tvalid = 1'b0; ld_if.data_tlast = 1'b0; ld_if.data_tdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(ld_if.busy), 64'd0);
    chk("rst_done", 64'(ld_if.ap_done), 64'd0);
    chk("rst_rs", 64'(ld_if.read_start), 64'd0);
    chk("rst_tready", 64'(ld_if.data_tready), 64'd0);
    chk("rst_wrv", 64'(ld_if.buf_wr_valid), 64'd0);
    chk("rst_err", 64'(ld_if.load_error), 64'd0);
    chk("rst_xaddr", ld_if.dram_xfer_start_addr, 64'd0);

    // Basic load into buffer 1, read_done after the last beat.
    run_load(3'b010, 16'd5, 16'd4, 4, 3, 1'b0, 1'b0);
    check_writes("basic", 3'b010, 5, 4);
    chk("basic_addr0", 64'(wr_addr_q[0][BAW +: BAW]), 64'd5);
    chk("basic_addr3", 64'(wr_addr_q[3][BAW +: BAW]), 64'd8);
    chk("basic_ndone", 64'(n_done), 64'd1);
    chk("basic_nrs", 64'(n_rs), 64'd1);
    chk("basic_err", 64'(ld_if.load_error), 64'd0);
    chk("basic_xaddr", ld_if.dram_xfer_start_addr, 64'h1000_0040);
    chk("basic_xsize", 64'(ld_if.dram_xfer_size_in_bytes), 64'h100);
    chk("basic_busy", 64'(ld_if.busy), 64'd0);

    // tvalid toggling 1,0,1,0.
    run_load(3'b010, 16'd5, 16'd4, 4, 3, 1'b1, 1'b0);
    check_writes("gaps", 3'b010, 5, 4);
    chk("gaps_ndone", 64'(n_done), 64'd1);

    // Address wrap, early read_done, minimum latencies.
    run_load(3'b001, 16'd2046, 16'd4, 4, 3, 1'b0, 1'b1);
    check_writes("wrap", 3'b001, 2046, 4);
    chk("wrap_a2", 64'(wr_addr_q[2][BAW-1:0]), 64'd0);
    chk("wrap_a3", 64'(wr_addr_q[3][BAW-1:0]), 64'd1);
    chk("lat_rs", 64'(rs_cyc - start_cyc), 64'd2);
    chk("lat_done", 64'(done_cyc - last_beat_cyc), 64'd2);

    // Zero-length instruction.
    run_load(3'b100, 16'd0, 16'd0, 0, -1, 1'b0, 1'b0);
    chk("zero_nrs", 64'(n_rs), 64'd0);
    chk("zero_nwr", 64'(wr_vld_q.size()), 64'd0);
    chk("zero_lat", 64'(done_cyc - start_cyc), 64'd2);
    chk("zero_err", 64'(ld_if.load_error), 64'd0);

    // Multi-hot group.
`ifdef LOAD_MULTI_BROADCAST_EN
    run_load(3'b011, 16'd10, 16'd3, 3, 2, 1'b0, 1'b1);
    check_writes("bcast", 3'b011, 10, 3);
    chk("bcast_err", 64'(ld_if.load_error), 64'd0);
`else
    run_load(3'b011, 16'd10, 16'd3, 0, -1, 1'b0, 1'b0);
    chk("multi_err", 64'(ld_if.load_error), 64'd1);
    chk("multi_nrs", 64'(n_rs), 64'd0);
    chk("multi_nwr", 64'(wr_vld_q.size()), 64'd0);
    chk("multi_ndone", 64'(n_done), 64'd1);
`endif

    // Empty group is always an error.
    run_load(3'b000, 16'd0, 16'd4, 0, -1, 1'b0, 1'b0);
    chk("nogrp_err", 64'(ld_if.load_error), 64'd1);
    chk("nogrp_nrs", 64'(n_rs), 64'd0);

    // Short stream: tlast on beat 2 of 4.
    run_load(3'b100, 16'd20, 16'd4, 2, 1, 1'b0, 1'b0);
    check_writes("short", 3'b100, 20, 2);
    chk("short_err", 64'(ld_if.load_error), 64'd1);
    chk("short_ndone", 64'(n_done), 64'd1);
    chk("short_after_rd", 64'(done_cyc > rd_cyc), 64'd1);

    // Reset while a beat is being accepted in STREAM.
    wr_vld_q.delete();
    @(negedge clk);
    ld_if.ctrl_instruction = build_inst(3'b010, 16'd0, 16'd8, 16'h0040, 16'h0100);
    ld_if.ap_start = 1'b1;
    @(negedge clk);
    ld_if.ap_start = 1'b0;
    chk("err_cleared", 64'(ld_if.load_error), 64'd0);
    for (int k = 0; k < 10 && !ld_if.data_tready; k++) @(negedge clk);
    chk("rst_reach_stream", 64'(ld_if.data_tready), 64'd1);
    ld_if.data_tvalid = 1'b1;
    ld_if.data_tdata  = DW'(55);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", 64'(ld_if.busy), 64'd0);
    chk("mid_tready", 64'(ld_if.data_tready), 64'd0);
    chk("mid_wrv", 64'(ld_if.buf_wr_valid), 64'd0);
    chk("mid_done", 64'(ld_if.ap_done), 64'd0);
    chk("mid_xaddr", ld_if.dram_xfer_start_addr, 64'd0);
    rst = 1'b0;
    ld_if.data_tvalid = 1'b0;
    @(negedge clk);
    chk("post_wrv", 64'(ld_if.buf_wr_valid), 64'd0);
    chk("post_busy", 64'(ld_if.busy), 64'd0);
    chk("post_nwr", 64'(wr_vld_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gnn_load_multi.md
Name: gnn_load_multi

Overview:
- Parametrised next-generation load engine. Decodes one load instruction, drives a DRAM read request, accepts the returned AXI4-Stream beats with real tvalid/tready handshaking, and writes them into one of NUM_BUF on-chip buffers.
- Sits between the control/instruction dispatcher and the buffer bank, in the same position as the current single-purpose load unit.
- Adds: configurable buffer count and address width, backpressure-correct stream, zero-length handling, wrap-around addressing, and error reporting for bad group or short stream.

Parameters:
- LOAD_INST_LENGTH, 96, instruction width; field layout fixed as below.
- C_M_AXI_ADDR_WIDTH, 64, DRAM byte address width.
- C_M_AXI_DATA_WIDTH, 512, beat and buffer word width.
- C_XFER_SIZE_WIDTH, 32, transfer size width.
- NUM_BUF, 3, number of target buffers, 1..6.
- BUF_ADDR_WIDTH, 11, buffer word address width.

Ports:
- kernel_clk  in  1  sole clock.
- kernel_rst  in  1  synchronous reset, active-high.
- ap_start  in  1  instruction valid; sampled only in IDLE.
- ap_done  out  1  one-cycle completion pulse.
- load_error  out  1  sticky error flag for the last instruction; cleared on next accepted ap_start.
- busy  out  1  high in every state except IDLE.
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  DRAM base offset.
- ctrl_instruction  in  LOAD_INST_LENGTH  group=[NUM_BUF-1:0] (one-hot), buf_start=[47:32], beat_len=[63:48], dram_start=[79:64], byte_len=[95:80].
- dram_xfer_start_addr  out  C_M_AXI_ADDR_WIDTH  ctrl_addr_offset + dram_start (zero-extended).
- dram_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  byte_len, zero-extended.
- read_start  out  1  one-cycle pulse to the AXI read master.
- read_done  in  1  read master finished; may arrive before or after the last beat.
- data_tvalid / data_tready / data_tlast  in/out/in  1  stream handshake.
- data_tdata  in  C_M_AXI_DATA_WIDTH  beat payload.
- buf_wr_valid  out  NUM_BUF  per-buffer write strobe.
- buf_wr_addr  out  NUM_BUF*BUF_ADDR_WIDTH  per-buffer word address; slice i belongs to buffer i.
- buf_wr_data  out  C_M_AXI_DATA_WIDTH  write data, shared by all buffers.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, latched instruction fields 0.
- States: IDLE, DECODE, ISSUE, STREAM, DRAIN, DONE.
- IDLE, ap_start=1: latch all instruction fields and offset, clear load_error, go to DECODE. ap_start outside IDLE is ignored.
- DECODE, group not one-hot (zero or multi-hot): set load_error, go to DONE, no read_start.
- DECODE, beat_len==0: go to DONE, no read_start, no error.
- DECODE, otherwise: go to ISSUE.
- ISSUE: read_start=1 for exactly one cycle, then STREAM. dram_xfer_* outputs hold stable from DECODE until DONE.
- STREAM: data_tready=1.
  - Each beat (tvalid&tready) registers a write one cycle later: buf_wr_valid[g]=1, address=(buf_start + count) mod 2^BUF_ADDR_WIDTH, data=tdata; count increments.
  - buf_wr_valid is 0 in any cycle without a beat in the previous cycle.
- End of stream:
  - When count reaches beat_len: if read_done has been seen (latched), go to DONE; else go to DRAIN.
  - tlast on a beat before count reaches beat_len: write that beat, set load_error, go to DRAIN (or DONE if read_done already seen).
- DRAIN: data_tready=1; extra beats are consumed and discarded, no writes. Leave on read_done, or immediately if read_done was already latched.
- DONE: ap_done=1 for one cycle, then IDLE. load_error stays valid until the next accepted ap_start.
- Minimum latency: ap_start to read_start is 2 cycles. With a gap-free stream and early read_done, the last beat to ap_done is 2 cycles.
- The last buffer write is issued no later than the ap_done cycle.
- Reset mid-operation: return immediately to IDLE with reset values. No ap_done and no buf write in the cycle after reset.

Optional Feature:
- Macro: LOAD_MULTI_BROADCAST_EN.
- Defined: a multi-hot group is legal and each beat is written to every selected buffer in the same cycle at the same address. An all-zero group is still an error.
- Undefined: multi-hot group is an error, handled as described in Behaviour.

Test Plan:
- group=3'b010, buf_start=5, beat_len=4, continuous beats D0..D3, read_done after the last beat -> buf_wr_valid=3'b010 at addresses 5,6,7,8; ap_done once; load_error=0.
- Same instruction, tvalid toggling 1,0,1,0 -> exactly 4 writes, no duplicates, addresses contiguous.
- buf_start=2046, beat_len=4 with BUF_ADDR_WIDTH=11 -> writes at addresses 2046, 2047, 0, 1.
- beat_len=0 -> no read_start; ap_done 2 cycles after ap_start; no writes.
- group=3'b011 without the macro -> load_error=1, ap_done, no read_start. With the macro -> buffers 0 and 1 are both written.
- beat_len=4, tlast on beat 2 -> 2 writes, load_error=1, ap_done after read_done. Separately, kernel_rst asserted mid-STREAM -> IDLE next cycle, all outputs 0.
